// File: rtl/ninjakun_pkg.sv
// Shared slot numbering, CPU handshake states and request payload for the Ninja-Kun tile VRAM port.
package ninjakun_pkg;

    localparam int unsigned VRAM_AW = 10;

    localparam logic [1:0] SLOT_VID  = 2'd0;
    localparam logic [1:0] SLOT_VCAP = 2'd1;
    localparam logic [1:0] SLOT_CPU  = 2'd2;
    localparam logic [1:0] SLOT_CLR  = 2'd3;

    typedef enum logic [1:0] {
        CPU_IDLE = 2'd0,
        CPU_PEND = 2'd1,
        CPU_ACK  = 2'd2
    } cpu_state_e;

    typedef struct packed {
        logic       wr;
        logic       lane;
        logic [7:0] di;
    } cpu_req_t;

    // Byte-enable for a CPU byte access: lane 0 = code[7:0], lane 1 = attr[15:8].
    function automatic logic [1:0] lane_be(input logic lane);
        return lane ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ninjakun_vram_spram.sv
// Single-port 2^AW x 16 synchronous RAM with byte enables and registered (read-before-write) output.
module ninjakun_vram_spram #(
    parameter int unsigned AW = 10
) (
    input  logic          vclk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [15:0] mem [DEPTH];

    always_ff @(posedge vclk) begin
        if (we && be[0]) mem[addr][7:0]  <= wdata[7:0];
        if (we && be[1]) mem[addr][15:8] <= wdata[15:8];
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ninjakun_vram_port.sv
// Tile VRAM responder: 4-slot time division between video fetch, CPU byte access and clear sweep.
// Optional power-on clear sweep is built when NINJAKUN_VRAM_CLEAR_EN is defined.
module ninjakun_vram_port
    import ninjakun_pkg::*;
#(
    parameter int unsigned AW     = VRAM_AW,
    parameter logic [15:0] INIT_W = 16'h0000
) (
    input  logic          VCLKx4,
    input  logic          RESET,
    input  logic [AW-1:0] VAD,
    output logic [15:0]   VDT,
    input  logic          CPUCS,
    input  logic          CPUWR,
    input  logic [AW:0]   CPUAD,
    input  logic [7:0]    CPUDI,
    output logic [7:0]    CPUDO,
    output logic          CPUWAIT,
    output logic          BUSY
);

    logic [1:0]    slot_q;
    cpu_state_e    state_q, state_d;
    cpu_req_t      req_q;
    logic [AW-1:0] req_ad_q;
    logic          req_load, svc, cap_q;
    logic          busy;
    logic [AW-1:0] clr_addr;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [1:0]    ram_be;
    logic [15:0]   ram_wdata, ram_rdata;

    always_ff @(posedge VCLKx4) begin
        if (RESET) slot_q <= SLOT_VID;
        else       slot_q <= 2'(slot_q + 2'd1);
    end

`ifdef NINJAKUN_VRAM_CLEAR_EN
    // One word per clear slot; a reset anywhere in the sweep restarts it from word 0.
    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            busy     <= 1'b1;
            clr_addr <= '0;
        end else if (busy && slot_q == SLOT_CLR) begin
            clr_addr <= AW'(clr_addr + 1'b1);
            if (&clr_addr) busy <= 1'b0;
        end
    end
`else
    assign busy     = 1'b0;
    assign clr_addr = '0;
`endif

    assign BUSY    = busy;
    assign CPUWAIT = CPUCS & (state_q != CPU_ACK);

    always_ff @(posedge VCLKx4) begin
        if (RESET) state_q <= CPU_IDLE;
        else       state_q <= state_d;
    end

    // ACK is left only when CS drops, so a held CS cannot start a second access.
    always_comb begin
        state_d  = state_q;
        req_load = 1'b0;
        svc      = 1'b0;
        case (state_q)
            CPU_IDLE: begin
                if (CPUCS) begin
                    state_d  = CPU_PEND;
                    req_load = 1'b1;
                end
            end
            CPU_PEND: begin
                if (slot_q == SLOT_CPU && !busy) begin
                    state_d = CPU_ACK;
                    svc     = 1'b1;
                end
            end
            CPU_ACK: begin
                if (!CPUCS) state_d = CPU_IDLE;
            end
            default: state_d = CPU_IDLE;
        endcase
    end

    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            req_q    <= '0;
            req_ad_q <= '0;
            cap_q    <= 1'b0;
        end else begin
            if (req_load) begin
                req_q.wr   <= CPUWR;
                req_q.lane <= CPUAD[AW];
                req_q.di   <= CPUDI;
                req_ad_q   <= CPUAD[AW-1:0];
            end
            cap_q <= svc & ~req_q.wr;
        end
    end

    // RAM port owner per slot; video address is the idle default.
    always_comb begin
        ram_addr  = VAD;
        ram_we    = 1'b0;
        ram_be    = 2'b00;
        ram_wdata = {req_q.di, req_q.di};
        case (slot_q)
            SLOT_VID: ram_addr = VAD;
            SLOT_CPU: begin
                if (svc) begin
                    ram_addr = req_ad_q;
                    ram_we   = req_q.wr;
                    ram_be   = lane_be(req_q.lane);
                end
            end
            SLOT_CLR: begin
                if (busy) begin
                    ram_addr  = clr_addr;
                    ram_we    = 1'b1;
                    ram_be    = 2'b11;
                    ram_wdata = INIT_W;
                end
            end
            default: ram_addr = VAD;
        endcase
    end

    ninjakun_vram_spram #(.AW(AW)) u_ram (
        .vclk  (VCLKx4),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            VDT   <= 16'h0000;
            CPUDO <= 8'h00;
        end else begin
            if (busy)                    VDT <= 16'h0000;
            else if (slot_q == SLOT_VCAP) VDT <= ram_rdata;
            if (cap_q) CPUDO <= req_q.lane ? ram_rdata[15:8] : ram_rdata[7:0];
        end
    end

endmodule

// File: tb/tb_ninjakun_vram_port.sv
// Directed bench for ninjakun_vram_port; clear-sweep steps are built with NINJAKUN_VRAM_CLEAR_EN.
module tb_ninjakun_vram_port;
    import ninjakun_pkg::*;

    localparam int unsigned AW = VRAM_AW;

    logic          VCLKx4 = 1'b0;
    logic          RESET;
    logic [AW-1:0] VAD;
    logic [15:0]   VDT;
    logic          CPUCS, CPUWR;
    logic [AW:0]   CPUAD;
    logic [7:0]    CPUDI, CPUDO;
    logic          CPUWAIT, BUSY;

    int vectors     = 0;
    int miscompares = 0;
    int slot        = 0;
    int n;
    logic [7:0]  d8;
    logic [15:0] d16;

    ninjakun_vram_port dut (
        .VCLKx4  (VCLKx4),
        .RESET   (RESET),
        .VAD     (VAD),
        .VDT     (VDT),
        .CPUCS   (CPUCS),
        .CPUWR   (CPUWR),
        .CPUAD   (CPUAD),
        .CPUDI   (CPUDI),
        .CPUDO   (CPUDO),
        .CPUWAIT (CPUWAIT),
        .BUSY    (BUSY)
    );

    always #5 VCLKx4 = ~VCLKx4;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // slot mirrors the DUT slot register value for the cycle following the edge.
    task automatic tick();
        logic r;
        r = RESET;
        @(posedge VCLKx4);
        #1;
        slot = r ? 0 : (slot + 1) % 4;
    endtask

    task automatic wait_slot(input int k);
        for (int i = 0; i < 4 && slot != k; i++) tick();
    endtask

    task automatic cpu_access(input logic wr, input logic [AW:0] ad, input logic [7:0] di,
                              output logic [7:0] dout);
        int m;
        CPUCS = 1'b1; CPUWR = wr; CPUAD = ad; CPUDI = di;
        #1;
        m = 0;
        while (CPUWAIT && m < 12) begin
            tick();
            m++;
        end
        check("cpu_wait_bound", 16'(CPUWAIT), 16'h0000);
        if (!wr) tick();
        dout  = CPUDO;
        CPUCS = 1'b0;
        tick();
    endtask

    task automatic vdt_read(input logic [AW-1:0] a, output logic [15:0] d);
        VAD = a;
        wait_slot(0);
        tick();
        tick();
        d = VDT;
    endtask

    initial begin
        RESET = 1'b1; CPUCS = 1'b0; CPUWR = 1'b0; CPUAD = '0; CPUDI = '0; VAD = '0;
        tick();
        tick();
        check("rst_vdt",   VDT,              16'h0000);
        check("rst_cpudo", 16'(CPUDO),       16'h0000);
        check("rst_wait",  16'(CPUWAIT),     16'h0000);
        RESET = 1'b0;
        n = 0;
        while (BUSY && n < 5000) begin
            tick();
            n++;
        end
        check("busy_low", 16'(BUSY), 16'h0000);

        // Word 0x010 = 7799, word 0x005 = A13C
        cpu_access(1'b1, 11'h010, 8'h99, d8);
        cpu_access(1'b1, 11'h410, 8'h77, d8);
        cpu_access(1'b1, 11'h005, 8'h3C, d8);
        cpu_access(1'b1, 11'h405, 8'hA1, d8);
        vdt_read(10'h010, d16);
        check("t1_pre", d16, 16'h7799);
        wait_slot(0);
        VAD = 10'h005;
        tick();
        check("t1_lat1", VDT, 16'h7799);
        tick();
        check("t1_vdt", VDT, 16'hA13C);
        for (int i = 0; i < 3; i++) tick();
        check("t1_hold", VDT, 16'hA13C);

        // Request raised in slot 3: four wait clocks, data one clock after WAIT drops
        wait_slot(3);
        CPUCS = 1'b1; CPUWR = 1'b0; CPUAD = 11'h405;
        #1;
        n = 0;
        while (CPUWAIT && n < 12) begin
            n++;
            tick();
        end
        check("t2_wait_clocks", 16'(n), 16'd4);
        tick();
        check("t2_cpudo", 16'(CPUDO), 16'h00A1);
        CPUCS = 1'b0;
        tick();
        check("t2_wait_idle", 16'(CPUWAIT), 16'h0000);

        // Code-lane write on word being fetched by video
        vdt_read(10'h010, d16);
        check("t3_pre", d16, 16'h7799);
        wait_slot(1);
        CPUCS = 1'b1; CPUWR = 1'b1; CPUAD = 11'h010; CPUDI = 8'h55;
        tick();
        tick();
        check("t3_wait", 16'(CPUWAIT), 16'h0000);
        CPUCS = 1'b0;
        tick();
        tick();
        check("t3_vdt_old", VDT, 16'h7799);
        tick();
        check("t3_vdt_new", VDT, 16'h7755);

        // CS held after ACK must not start another write
        CPUCS = 1'b1; CPUWR = 1'b1; CPUAD = 11'h020; CPUDI = 8'h11;
        #1;
        n = 0;
        while (CPUWAIT && n < 12) begin
            tick();
            n++;
        end
        check("t4_served", 16'(CPUWAIT), 16'h0000);
        CPUDI = 8'hEE;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (CPUWAIT) n++;
        end
        check("t4_held_wait", 16'(n), 16'h0000);
        CPUCS = 1'b0;
        tick();
        cpu_access(1'b1, 11'h420, 8'h22, d8);
        vdt_read(10'h020, d16);
        check("t4_word", d16, 16'h2211);
        cpu_access(1'b0, 11'h020, 8'h00, d8);
        check("t4_rd_code", 16'(d8), 16'h0011);

        // Reset while a write is pending
        cpu_access(1'b0, 11'h010, 8'h00, d8);
        check("t5_pre_rd", 16'(d8), 16'h0055);
        cpu_access(1'b1, 11'h030, 8'h34, d8);
        cpu_access(1'b1, 11'h430, 8'h12, d8);
        vdt_read(10'h005, d16);
        check("t5_pre_vdt", d16, 16'hA13C);
        wait_slot(3);
        CPUCS = 1'b1; CPUWR = 1'b1; CPUAD = 11'h030; CPUDI = 8'h5A;
        tick();
        RESET = 1'b1;
        CPUDI = 8'h66;
        tick();
        RESET = 1'b0;
        check("t5_cpudo_rst", 16'(CPUDO),   16'h0000);
        check("t5_vdt_rst",   VDT,          16'h0000);
        check("t5_wait_rst",  16'(CPUWAIT), 16'h0001);
`ifdef NINJAKUN_VRAM_CLEAR_EN
        n = 0;
        while (BUSY && n < 5000) begin
            tick();
            n++;
        end
        check("t5_busy_low", 16'(BUSY), 16'h0000);
`else
        tick();
        check("t5_slot_a", VDT, 16'h0000);
        tick();
        check("t5_slot_b", VDT, 16'hA13C);
`endif
        n = 0;
        while (CPUWAIT && n < 12) begin
            tick();
            n++;
        end
        check("t5_reserved", 16'(CPUWAIT), 16'h0000);
        CPUCS = 1'b0;
        tick();
        vdt_read(10'h030, d16);
`ifdef NINJAKUN_VRAM_CLEAR_EN
        check("t5_word", d16, 16'h0066);
`else
        check("t5_word", d16, 16'h1266);
`endif

`ifdef NINJAKUN_VRAM_CLEAR_EN
        // Clear sweep over preloaded words, CPU read stalled for the whole sweep
        cpu_access(1'b1, 11'h000, 8'hFF, d8);
        cpu_access(1'b1, 11'h400, 8'hFF, d8);
        cpu_access(1'b1, 11'h005, 8'hFF, d8);
        cpu_access(1'b1, 11'h405, 8'hFF, d8);
        cpu_access(1'b1, 11'h3FF, 8'hFF, d8);
        cpu_access(1'b1, 11'h7FF, 8'hFF, d8);
        vdt_read(10'h005, d16);
        check("t6_pre", d16, 16'hFFFF);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        CPUCS = 1'b1; CPUWR = 1'b0; CPUAD = 11'h405;
        #1;
        begin
            int waitlow, vdtnz;
            waitlow = 0;
            vdtnz   = 0;
            n       = 0;
            while (BUSY && n < 5000) begin
                if (!CPUWAIT) waitlow++;
                if (VDT !== 16'h0000) vdtnz++;
                tick();
                n++;
            end
            check("t6_busy_clocks", 16'(n),       16'd4096);
            check("t6_cpu_waited",  16'(waitlow), 16'h0000);
            check("t6_vdt_forced",  16'(vdtnz),   16'h0000);
        end
        n = 0;
        while (CPUWAIT && n < 12) begin
            tick();
            n++;
        end
        check("t6_served", 16'(CPUWAIT), 16'h0000);
        tick();
        check("t6_cpudo", 16'(CPUDO), 16'h0000);
        CPUCS = 1'b0;
        tick();
        begin
            int errs;
            errs = 0;
            for (int a = 0; a < (1 << AW); a++) begin
                vdt_read(AW'(a), d16);
                if (d16 !== 16'h0000) errs++;
            end
            check("t6_readback", 16'(errs), 16'h0000);
        end
`else
        check("busy_tied", 16'(BUSY), 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
